// File: rtl/local_spike_interface_pkg.sv
// Shared constants and helpers for the router-to-neuron local-port interface.
package local_spike_interface_pkg;

    // Axon index occupies the least-significant bits of every packet.
    localparam int AXON_IDX_LSB = 0;

    // Number of flits that make up one packet.
    function automatic int flits_per_pkt(input int packet_size, input int flit_size);
        return packet_size / flit_size;
    endfunction

    // Counter/pointer width for n states, never narrower than one bit.
    function automatic int min1_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/local_spike_interface_if.sv
// Router local-port and neuron-side signal bundle.
interface local_spike_interface_if #(
    parameter int FLIT_SIZE          = 4,
    parameter int NUM_AXONS          = 2,
    parameter int AXON_CNT_BIT_WIDTH = 1
);
    logic                          write_en;
    logic [FLIT_SIZE-1:0]          data_in;
    logic                          start;
    logic [NUM_AXONS-1:0]          spike;
    logic [AXON_CNT_BIT_WIDTH:0]   spike_cnt;
    logic                          neuron_full;
    logic                          overflow_err;
    logic                          range_err;

    // Router / timestep source side.
    modport master (
        output write_en, data_in, start,
        input  spike, spike_cnt, neuron_full, overflow_err, range_err
    );

    // Interface block side.
    modport slave (
        input  write_en, data_in, start,
        output spike, spike_cnt, neuron_full, overflow_err, range_err
    );
endinterface

// File: rtl/local_spike_interface_spike_pkt_fifo.sv
// Whole-packet FIFO between flit reassembly and axon decode.
module spike_pkt_fifo
    import local_spike_interface_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [min1_clog2(DEPTH):0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = min1_clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    // A push into a full FIFO is only accepted when a pop frees a slot on the same edge.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = count_q;

    // Packet storage; contents need no reset because count_q gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/local_spike_interface.sv
// Router-to-neuron local port: reassembles flits into packets, buffers them,
// decodes axon indices into a per-timestep spike vector and raises backpressure.
module local_spike_interface
    import local_spike_interface_pkg::*;
#(
    parameter int PACKET_SIZE        = 32,
    parameter int FLIT_SIZE          = 4,
    parameter int NUM_AXONS          = 2,
    parameter int AXON_CNT_BIT_WIDTH = 1,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    local_spike_interface_if.slave bus
);
    localparam int FLITS = flits_per_pkt(PACKET_SIZE, FLIT_SIZE);
    localparam int FC_W  = min1_clog2(FLITS);
    localparam int FQ_W  = min1_clog2(FIFO_DEPTH) + 1;
    localparam logic [FC_W-1:0]               LAST_FLIT  = FC_W'(FLITS - 1);
    localparam logic [FQ_W:0]                 FULL_LEVEL = (FQ_W+1)'(FIFO_DEPTH);
    localparam logic [AXON_CNT_BIT_WIDTH:0]   AXON_LIMIT = (AXON_CNT_BIT_WIDTH+1)'(NUM_AXONS);

    logic [FC_W-1:0]                 flit_cnt;
    logic [PACKET_SIZE-FLIT_SIZE-1:0] shift_reg;
    logic [PACKET_SIZE-1:0]          pkt_in;
    logic                            last_flit;
    logic                            pop;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic [FQ_W-1:0]                 fifo_count;
    logic [PACKET_SIZE-1:0]          fifo_dout;
    logic [AXON_CNT_BIT_WIDTH-1:0]   idx;
    logic                            idx_ok;
    logic [NUM_AXONS-1:0]            pop_onehot;
    logic [NUM_AXONS-1:0]            acc_p0;
    logic [NUM_AXONS-1:0]            spike_p1;
    logic [AXON_CNT_BIT_WIDTH:0]     spike_cnt_p1;
    logic                            overflow_q;
    logic                            range_q;
    logic                            unused_pkt_bits;

    function automatic logic [AXON_CNT_BIT_WIDTH:0] popcount(input logic [NUM_AXONS-1:0] v);
        logic [AXON_CNT_BIT_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < NUM_AXONS; i++) begin
            c = c + {{AXON_CNT_BIT_WIDTH{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Current flit joins the earlier ones at the low end; the first flit ends up MS.
    assign pkt_in    = {shift_reg, bus.data_in};
    assign last_flit = bus.write_en && (flit_cnt == LAST_FLIT);

    // Drain runs whenever a packet is buffered.
    assign pop = !fifo_empty;

    // Destination fields travel with the packet but are not needed past the router.
    assign idx             = fifo_dout[AXON_IDX_LSB +: AXON_CNT_BIT_WIDTH];
    assign unused_pkt_bits = ^fifo_dout[PACKET_SIZE-1:AXON_IDX_LSB+AXON_CNT_BIT_WIDTH];
    assign idx_ok          = ({1'b0, idx} < AXON_LIMIT);
    assign pop_onehot      = (pop && idx_ok) ? (NUM_AXONS'(1) << idx) : '0;

    // A partially received packet already claims a FIFO slot.
    assign bus.neuron_full  = ({1'b0, fifo_count} + {{FQ_W{1'b0}}, (flit_cnt != '0)}) >= FULL_LEVEL;
    assign bus.spike        = spike_p1;
    assign bus.spike_cnt    = spike_cnt_p1;
    assign bus.overflow_err = overflow_q;
    assign bus.range_err    = range_q;

    spike_pkt_fifo #(
        .WIDTH (PACKET_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (last_flit),
        .pop   (pop),
        .din   (pkt_in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Flit position within the packet; wraps even when the packet is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            flit_cnt <= '0;
        end else if (bus.write_en) begin
            flit_cnt <= last_flit ? '0 : flit_cnt + 1'b1;
        end
    end

    // Holds the leading flits of the packet in flight.
    always_ff @(posedge clk) begin
        if (bus.write_en) begin
            shift_reg <= pkt_in[PACKET_SIZE-FLIT_SIZE-1:0];
        end
    end

    // Spike accumulation; a pop on the start edge belongs to the new timestep.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_p0       <= '0;
            spike_p1     <= '0;
            spike_cnt_p1 <= '0;
        end else begin
            acc_p0 <= (bus.start ? '0 : acc_p0) | pop_onehot;
            if (bus.start) begin
                spike_p1     <= acc_p0;
                spike_cnt_p1 <= popcount(acc_p0);
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            range_q    <= 1'b0;
        end else begin
            if (last_flit && fifo_full && !pop) overflow_q <= 1'b1;
            if (pop && !idx_ok)                 range_q    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_local_spike_interface.sv
// Scoreboard bench: two DUT configurations, directed vectors plus a short random run.
module tb_local_spike_interface;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    local_spike_interface_if #(.FLIT_SIZE(4), .NUM_AXONS(2), .AXON_CNT_BIT_WIDTH(1)) ia ();
    local_spike_interface_if #(.FLIT_SIZE(4), .NUM_AXONS(3), .AXON_CNT_BIT_WIDTH(2)) ib ();

    local_spike_interface #(
        .PACKET_SIZE(32), .FLIT_SIZE(4), .NUM_AXONS(2), .AXON_CNT_BIT_WIDTH(1), .FIFO_DEPTH(4)
    ) dut_a (.clk(clk), .reset(reset), .bus(ia));

    local_spike_interface #(
        .PACKET_SIZE(32), .FLIT_SIZE(4), .NUM_AXONS(3), .AXON_CNT_BIT_WIDTH(2), .FIFO_DEPTH(2)
    ) dut_b (.clk(clk), .reset(reset), .bus(ib));

    int errors = 0;
    int checks = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    // Random-phase model of instance A
    bit       use_model = 1'b0;
    bit [1:0] acc_m = 2'b00;
    bit       pend_v = 1'b0;
    bit       pend_idx = 1'b0;

    function automatic logic [7:0] mk(input logic [2:0] sp, input logic [2:0] c, input logic o, input logic r);
        return {sp, c, o, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus on instance A (sel=0) or B (sel=1).
    task automatic cyc(input bit sel, input bit we, input logic [3:0] d, input bit st,
                       input bit last, input bit idx);
        @(negedge clk);
        if (!sel) begin
            ia.write_en = we; ia.data_in = d; ia.start = st;
            if (use_model) begin
                if (st) q_a.push_back(mk({1'b0, acc_m}, {1'b0, 2'(acc_m[0]) + 2'(acc_m[1])}, 1'b0, 1'b0));
                acc_m    = (st ? 2'b00 : acc_m) | (pend_v ? (2'b01 << pend_idx) : 2'b00);
                pend_v   = we && last;
                pend_idx = idx;
            end
        end else begin
            ib.write_en = we; ib.data_in = d; ib.start = st;
        end
    endtask

    task automatic send_pkt(input bit sel, input logic [31:0] pkt);
        for (int i = 0; i < 8; i++) cyc(sel, 1'b1, pkt[31-4*i -: 4], 1'b0, (i == 7), pkt[0]);
    endtask

    task automatic idle(input bit sel, input int n);
        repeat (n) cyc(sel, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_start(input bit sel);
        cyc(sel, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor A: compare after every accepted start
    initial begin
        logic s;
        forever begin
            @(posedge clk);
            s = ia.start && !reset;
            @(negedge clk);
            if (s) begin
                if (q_a.size() == 0) check("a_unexpected_start", 32'd1, 32'd0);
                else check("a_timestep", mk({1'b0, ia.spike}, {1'b0, ia.spike_cnt}, ia.overflow_err, ia.range_err), q_a.pop_front());
            end
        end
    end

    // Monitor B
    initial begin
        logic s;
        forever begin
            @(posedge clk);
            s = ib.start && !reset;
            @(negedge clk);
            if (s) begin
                if (q_b.size() == 0) check("b_unexpected_start", 32'd1, 32'd0);
                else check("b_timestep", mk(ib.spike, ib.spike_cnt, ib.overflow_err, ib.range_err), q_b.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        ia.write_en = 0; ia.data_in = 0; ia.start = 0;
        ib.write_en = 0; ib.data_in = 0; ib.start = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("a_reset_outputs", {ia.spike, ia.spike_cnt, ia.neuron_full, ia.overflow_err, ia.range_err}, 0);
        check("b_reset_outputs", {ib.spike, ib.spike_cnt, ib.neuron_full, ib.overflow_err, ib.range_err}, 0);
        reset = 1'b0;

        // Single idx1 packet
        send_pkt(0, 32'h0000_0001);
        idle(0, 1);
        q_a.push_back(mk(3'b010, 3'd1, 1'b0, 1'b0));
        pulse_start(0);
        idle(0, 1);

        // Duplicate idx1, idx0 popped on the start edge
        send_pkt(0, 32'h0000_0001);
        send_pkt(0, 32'h0000_0001);
        send_pkt(0, 32'h0000_0000);
        q_a.push_back(mk(3'b010, 3'd1, 1'b0, 1'b0));
        pulse_start(0);
        idle(0, 1);
        q_a.push_back(mk(3'b001, 3'd1, 1'b0, 1'b0));
        pulse_start(0);
        idle(0, 1);

        // Reset in the middle of a packet
        cyc(0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        cyc(0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        cyc(0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1; ia.write_en = 1'b0;
        @(negedge clk);
        check("a_during_reset", {ia.spike, ia.spike_cnt, ia.neuron_full, ia.overflow_err, ia.range_err}, 0);
        reset = 1'b0;
        send_pkt(0, 32'h0000_1000);
        idle(0, 2);
        q_a.push_back(mk(3'b001, 3'd1, 1'b0, 1'b0));
        pulse_start(0);
        idle(0, 1);

        // Backpressure and overflow on B with the drain stalled
        force dut_b.pop = 1'b0;
        send_pkt(1, 32'h0000_0000);
        idle(1, 1);
        check("b_nfull_after_pkt1", ib.neuron_full, 0);
        check("b_count_after_pkt1", dut_b.fifo_count, 1);
        cyc(1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        idle(1, 1);
        check("b_nfull_first_flit_pkt2", ib.neuron_full, 1);
        for (int i = 1; i < 8; i++) cyc(1, 1'b1, (i == 7) ? 4'h1 : 4'h0, 1'b0, 1'b0, 1'b0);
        idle(1, 1);
        check("b_count_after_pkt2", dut_b.fifo_count, 2);
        check("b_ovf_before_pkt3", ib.overflow_err, 0);
        send_pkt(1, 32'h0000_0002);
        idle(1, 1);
        check("b_ovf_after_pkt3", ib.overflow_err, 1);
        check("b_count_after_pkt3", dut_b.fifo_count, 2);
        release dut_b.pop;
        idle(1, 3);
        check("b_nfull_drained", ib.neuron_full, 0);
        q_b.push_back(mk(3'b011, 3'd2, 1'b1, 1'b0));
        pulse_start(1);
        idle(1, 1);

        // Out-of-range axon index on B
        send_pkt(1, 32'h0000_0003);
        send_pkt(1, 32'h0000_0002);
        idle(1, 2);
        check("b_range_err", ib.range_err, 1);
        q_b.push_back(mk(3'b100, 3'd1, 1'b1, 1'b1));
        pulse_start(1);
        idle(1, 1);

        // Random packets and starts on A against the model
        acc_m = 2'b00; pend_v = 1'b0; use_model = 1'b1;
        for (int p = 0; p < 30; p++) begin
            logic [31:0] pk;
            pk = $urandom();
            for (int i = 0; i < 8; i++) begin
                cyc(0, 1'b1, pk[31-4*i -: 4], ($urandom_range(0, 9) == 0), (i == 7), pk[0]);
                if ($urandom_range(0, 3) == 0)
                    cyc(0, 1'b0, 4'h0, ($urandom_range(0, 9) == 0), 1'b0, 1'b0);
            end
        end
        idle(0, 2);
        pulse_start(0);
        idle(0, 3);

        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
